color_sample_calib: RTL
=======================

# color_sample_calib

Calibration block that produces the reference colour and tolerance consumed by the per-channel colour comparators in the ball locator. On a `start` request it waits for the next frame and captures the RGB pixels inside a fixed square window (the ball placed at plate centre). It tracks the per-channel minimum and maximum over those pixels and publishes `sample = midrange` and `threshold = half-range + 1 + MARGIN`. Every training pixel then satisfies the comparator's strict `|pixel − sample| < threshold`.

## Interface
- `IMG_W`, 640, active pixels per line
- `IMG_H`, 480, active lines per frame
- `WIN_X0`, 312, window left column
- `WIN_Y0`, 232, window top line
- `WIN_SIZE`, 16, window edge in pixels; must satisfy `WIN_X0+WIN_SIZE ≤ IMG_W` and `WIN_Y0+WIN_SIZE ≤ IMG_H`
- `MARGIN`, 4, extra tolerance added to each threshold, 0..255

Ports:
- `clk_100M`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  calibration request, single-cycle pulse
- `pixel_valid`  in  1  pixel qualifier
- `sof`  in  1  start of frame; qualified by `pixel_valid`, marks pixel (0,0)
- `pixel_rgb`  in  24  pixel colour {R[23:16], G[15:8], B[7:0]}
- `sample_r/g/b`  out  8 each  learned reference colour
- `thr_r/g/b`  out  8 each  learned thresholds
- `cal_valid`  out  1  high once any calibration has completed
- `busy`  out  1  calibration in progress
- `done`  out  1  one-cycle pulse when new results are visible

## Operation
- All outputs reset to 0. With a zero threshold the comparators report no match before calibration.
- FSM states: IDLE, ARM, COLLECT, CALC.
  - IDLE: `start` → ARM. `start` is ignored in every other state.
  - ARM: wait for `sof & pixel_valid`. On that cycle go to COLLECT, set x=0 and y=0, and process that pixel.
  - COLLECT: each `pixel_valid` advances x. x wraps at `IMG_W-1` and increments y. y is not wrapped; `sof` resets it.
    - A pixel is in the window when `WIN_X0 ≤ x < WIN_X0+WIN_SIZE` and `WIN_Y0 ≤ y < WIN_Y0+WIN_SIZE`. In-window pixels update per-channel min/max.
    - Processing the pixel at (`WIN_X0+WIN_SIZE-1`, `WIN_Y0+WIN_SIZE-1`) → CALC.
    - `sof & pixel_valid` in COLLECT (short or aborted frame): reinitialise min/max and counters. Treat that pixel as (0,0) and stay in COLLECT.
  - CALC: latch the outputs, → IDLE.
- min/max are initialised to 255/0 on entry to COLLECT.
- Arithmetic per channel:
  - `sample = (min+max)>>1`, using a 9-bit sum.
  - `thr = ((max−min)>>1) + 1 + MARGIN`, using a 10-bit intermediate, saturated to 255.
- Results hold until the next completed calibration or reset. Intermediate min/max are never visible on the outputs.
- `busy` = state ≠ IDLE.
- `cal_valid` is set in the CALC cycle and stays set until reset.
- `pixel_valid` gaps of any length are allowed. Pixels arriving while in IDLE are ignored.

## Timing
- Let N be the cycle in which the last window pixel is accepted.
  - N+1: CALC.
  - N+2: new outputs visible, `done`=1 for exactly one cycle, `cal_valid`=1, `busy`=0.
- `busy` rises the cycle after `start` is accepted.
- `start` in the same cycle as `done` is accepted, because the FSM is in IDLE.
- Reset in any state takes effect at the next edge:
  - FSM → IDLE.
  - All outputs → 0, including previously learned values.
  - `done` is not asserted.
- Latency from `start` to `done` depends on frame timing: at most one partial frame plus one frame to the window, plus 2 cycles.

## Structure
- Shared package, also used by the comparators:
  - channel width constant (8)
  - FSM state encoding
  - RGB field offsets
- One sub-module, `color_range_tracker`, instantiated three times (one per channel). It contains:
  - min/max registers with init/update enables
  - midrange and saturated-threshold calculation with output registers
- The top level holds the FSM, the x/y counters and the window decode.

## Test plan
- Reset: hold `rst_n`=0 then release → all samples/thr 0, `cal_valid`=0, `busy`=0. Pulse `start` with no `sof` → `busy` stays 1 indefinitely, `done` never asserted.
- Uniform window, all channels 100, outside pixels 0 → sample 100/100/100, thr 5/5/5. `done` exactly 2 cycles after pixel (327,247). Random `pixel_valid` gaps give the same result.
- Spread: R ramps 10..250 across the window, G=60, B alternates 0/255 → sample 130/60/127, thr 125/5/132.
- Saturation: `MARGIN`=200, window R spans 0..255 → thr_r 255, sample_r 127.
- Restart/abort: `sof` injected mid-COLLECT at line 240, then a full frame with window colour 50 → results reflect only the second frame (sample 50, thr 5), single `done` pulse. A second `start` during collection has no effect.
- Reset mid-COLLECT after a prior calibration → outputs cleared to 0, `cal_valid`=0, no `done`. A fresh `start` calibrates normally.

Source files
------------

// File: rtl/color_sample_calib_pkg.sv
// -----------------------------------------------------------------------------
// color_sample_calib_pkg
// Shared definitions for the colour calibration block and the per-channel
// colour comparators: channel width, RGB field offsets, calibration FSM
// state encoding and a channel-extraction helper.
// -----------------------------------------------------------------------------
package color_sample_calib_pkg;

   localparam int unsigned CH_W  = 8;
   localparam int unsigned RGB_W = 3 * CH_W;

   // Bit offsets of each channel inside a packed {R, G, B} pixel
   localparam int unsigned R_LSB = 2 * CH_W;
   localparam int unsigned G_LSB = CH_W;
   localparam int unsigned B_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_COLLECT = 2'd2,
      ST_CALC    = 2'd3
   } cal_state_e;

   function automatic logic [CH_W-1:0] rgb_chan(input logic [RGB_W-1:0] rgb,
                                                input int unsigned       lsb);
      return rgb[lsb +: CH_W];
   endfunction

endpackage

// File: rtl/color_sample_calib_if.sv
// -----------------------------------------------------------------------------
// color_sample_calib_if
// Pixel stream + calibration result bundle.
//   master : pixel source / result consumer (drives start, pixel_valid, sof,
//            pixel_rgb; reads sample_*, thr_*, cal_valid, busy, done)
//   slave  : the calibration block
// -----------------------------------------------------------------------------
interface color_sample_calib_if;
   import color_sample_calib_pkg::*;

   logic              start;
   logic              pixel_valid;
   logic              sof;
   logic [RGB_W-1:0]  pixel_rgb;
   logic [CH_W-1:0]   sample_r;
   logic [CH_W-1:0]   sample_g;
   logic [CH_W-1:0]   sample_b;
   logic [CH_W-1:0]   thr_r;
   logic [CH_W-1:0]   thr_g;
   logic [CH_W-1:0]   thr_b;
   logic              cal_valid;
   logic              busy;
   logic              done;

   modport master (
      output start, pixel_valid, sof, pixel_rgb,
      input  sample_r, sample_g, sample_b, thr_r, thr_g, thr_b,
             cal_valid, busy, done
   );

   modport slave (
      input  start, pixel_valid, sof, pixel_rgb,
      output sample_r, sample_g, sample_b, thr_r, thr_g, thr_b,
             cal_valid, busy, done
   );

endinterface

// File: rtl/color_sample_calib_range_tracker.sv
// -----------------------------------------------------------------------------
// color_range_tracker
// Single-channel min/max tracker with registered midrange / threshold output.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   init_i        : restart tracking (min=all-ones, max=0) this cycle
//   upd_i         : fold pix_i into min/max (combines with init_i)
//   pix_i         : channel value of the current pixel
//   load_i        : publish sample/threshold computed from current min/max
//   sample_o      : (min+max)>>1
//   thr_o         : ((max-min)>>1) + 1 + MARGIN, saturated to all-ones
// -----------------------------------------------------------------------------
module color_range_tracker
   import color_sample_calib_pkg::*;
#(
   parameter int unsigned MARGIN = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            init_i,
   input  logic            upd_i,
   input  logic [CH_W-1:0] pix_i,
   input  logic            load_i,
   output logic [CH_W-1:0] sample_o,
   output logic [CH_W-1:0] thr_o
);

   localparam logic [CH_W+1:0] THR_MAX = (CH_W+2)'((1 << CH_W) - 1);

   logic [CH_W-1:0] min_q, min_d;
   logic [CH_W-1:0] max_q, max_d;
   logic [CH_W-1:0] sample_q, sample_d;
   logic [CH_W-1:0] thr_q, thr_d;
   logic [CH_W:0]   sum;
   logic [CH_W-1:0] half_range;
   logic [CH_W+1:0] thr_wide;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      // init and update in the same cycle: the first pixel seeds the range
      if (init_i) begin
         min_d = '1;
         max_d = '0;
      end
      if (upd_i) begin
         if (pix_i < min_d) min_d = pix_i;
         if (pix_i > max_d) max_d = pix_i;
      end

      sum        = {1'b0, min_q} + {1'b0, max_q};
      sample_d   = sum[CH_W:1];
      half_range = (max_q - min_q) >> 1;
      thr_wide   = {2'b00, half_range} + (CH_W+2)'(1) + (CH_W+2)'(MARGIN);
      thr_d      = (thr_wide > THR_MAX) ? '1 : thr_wide[CH_W-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         min_q    <= '1;
         max_q    <= '0;
         sample_q <= '0;
         thr_q    <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
         if (load_i) begin
            sample_q <= sample_d;
            thr_q    <= thr_d;
         end
      end
   end

   assign sample_o = sample_q;
   assign thr_o    = thr_q;

endmodule

// File: rtl/color_sample_calib.sv
// -----------------------------------------------------------------------------
// color_sample_calib
// Learns a reference colour and tolerance from a square window of the next
// frame after a start request.
//   clk_100M : system clock
//   rst_n    : synchronous active-low reset
//   bus      : slave side of color_sample_calib_if
//              in : start, pixel_valid, sof, pixel_rgb
//              out: sample_r/g/b, thr_r/g/b, cal_valid, busy, done
// -----------------------------------------------------------------------------
module color_sample_calib
   import color_sample_calib_pkg::*;
#(
   parameter int unsigned IMG_W    = 640,
   parameter int unsigned IMG_H    = 480,
   parameter int unsigned WIN_X0   = 312,
   parameter int unsigned WIN_Y0   = 232,
   parameter int unsigned WIN_SIZE = 16,
   parameter int unsigned MARGIN   = 4
) (
   input logic                clk_100M,
   input logic                rst_n,
   color_sample_calib_if.slave bus
);

   localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned YW = $clog2(IMG_H + 1);

   localparam logic [XW-1:0] X_LO  = XW'(WIN_X0);
   localparam logic [XW-1:0] X_HI  = XW'(WIN_X0 + WIN_SIZE - 1);
   localparam logic [XW-1:0] X_END = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LO  = YW'(WIN_Y0);
   localparam logic [YW-1:0] Y_HI  = YW'(WIN_Y0 + WIN_SIZE - 1);

   cal_state_e    state_q, state_d;
   logic [XW-1:0] x_q, x_d, cur_x;
   logic [YW-1:0] y_q, y_d, cur_y;
   logic          take, init, in_win, upd, last_px, calc;
   logic          done_q, cal_valid_q;

   // x_q/y_q hold the coordinate of the next expected pixel; an sof pixel
   // overrides them with (0,0) so it is processed like any other pixel.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      take    = 1'b0;
      init    = 1'b0;
      cur_x   = x_q;
      cur_y   = y_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (bus.pixel_valid && bus.sof) begin
               take    = 1'b1;
               init    = 1'b1;
               state_d = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (bus.pixel_valid) begin
               take = 1'b1;
               init = bus.sof;
            end
         end
         ST_CALC: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (init) begin
         cur_x = '0;
         cur_y = '0;
      end

      in_win  = (cur_x >= X_LO) && (cur_x <= X_HI) &&
                (cur_y >= Y_LO) && (cur_y <= Y_HI);
      upd     = take && in_win;
      last_px = upd && (cur_x == X_HI) && (cur_y == Y_HI);

      if (take) begin
         if (cur_x == X_END) begin
            x_d = '0;
            y_d = cur_y + YW'(1);
         end else begin
            x_d = cur_x + XW'(1);
            y_d = cur_y;
         end
      end

      if (last_px) state_d = ST_CALC;
   end

   assign calc = (state_q == ST_CALC);

   always_ff @(posedge clk_100M) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         done_q      <= 1'b0;
         cal_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         done_q      <= calc;
         cal_valid_q <= cal_valid_q | calc;
      end
   end

   color_range_tracker #(.MARGIN(MARGIN)) u_trk_r (
      .clk_i    (clk_100M),
      .rst_ni   (rst_n),
      .init_i   (init),
      .upd_i    (upd),
      .pix_i    (rgb_chan(bus.pixel_rgb, R_LSB)),
      .load_i   (calc),
      .sample_o (bus.sample_r),
      .thr_o    (bus.thr_r)
   );

   color_range_tracker #(.MARGIN(MARGIN)) u_trk_g (
      .clk_i    (clk_100M),
      .rst_ni   (rst_n),
      .init_i   (init),
      .upd_i    (upd),
      .pix_i    (rgb_chan(bus.pixel_rgb, G_LSB)),
      .load_i   (calc),
      .sample_o (bus.sample_g),
      .thr_o    (bus.thr_g)
   );

   color_range_tracker #(.MARGIN(MARGIN)) u_trk_b (
      .clk_i    (clk_100M),
      .rst_ni   (rst_n),
      .init_i   (init),
      .upd_i    (upd),
      .pix_i    (rgb_chan(bus.pixel_rgb, B_LSB)),
      .load_i   (calc),
      .sample_o (bus.sample_b),
      .thr_o    (bus.thr_b)
   );

   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = done_q;
   assign bus.cal_valid = cal_valid_q;

endmodule
